embed_stream_reader: RTL and testbench
======================================

Name: embed_stream_reader

Overview:
- Downstream consumer of the patch-embedding RAM stage.
- Once the embedding RAM reports ready, the block generates sequential read addresses and compensates for the RAM's fixed 2-clock read latency.
- Returned 64-bit words (32 packed 2-bit sum/carry fields) are buffered in a small FIFO and presented to the next transformer stage on a valid/ready stream.
- Back-pressure never causes a returned word to be dropped.

Parameters:
- DATA_W, 64, width of one RAM word / stream beat
- ADDR_W, 12, RAM read-address width
- NUM_WORDS, 4096, words per frame; legal range 1..2^ADDR_W
- RD_LAT, 2, RAM read latency in clocks from address to data
- FIFO_DEPTH, 4, output buffer entries; power of two, must be >= RD_LAT+1

Ports:
- s_clk  in  1  clock
- s_rst  in  1  asynchronous reset, active-high
- i_start  in  1  one-cycle pulse; begins a frame read
- i_ram_ready  in  1  embedding RAM contents valid
- o_rd_addr  out  ADDR_W  RAM read address
- i_rd_data  in  DATA_W  RAM read data, valid RD_LAT clocks after the address
- o_data  out  DATA_W  stream data (FIFO head)
- o_valid  out  1  stream valid
- i_ready  in  1  downstream accepts the beat when o_valid && i_ready
- o_last  out  1  high with the final beat of the frame
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset values: o_rd_addr=0, o_valid=0, o_last=0, o_busy=0, o_done=0, o_data=0. FIFO is empty, in-flight counter is 0, state is IDLE. Reset mid-frame aborts the frame; no partial o_done.
- FSM states: IDLE, WAIT_RDY, ISSUE, DRAIN, DONE.
- IDLE: on i_start go to WAIT_RDY and set o_busy=1. i_start in any other state is ignored.
- WAIT_RDY: when i_ram_ready=1, go to ISSUE with issue counter=0.
- ISSUE:
  - Each cycle where credit = FIFO_DEPTH - (fifo_count + inflight) > 0, drive o_rd_addr = counter and mark the read issued.
  - A shift register of depth RD_LAT tracks issued reads and their last flag.
  - When counter reaches NUM_WORDS-1 and that read is issued, go to DRAIN.
  - With no credit, o_rd_addr holds and nothing is issued.
- DRAIN: wait until inflight==0, the FIFO is empty, and the last beat has been accepted; then go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, return to IDLE.
- Data capture: RD_LAT clocks after an issue, i_rd_data is written into the FIFO tail along with the last flag.
  - The credit rule guarantees the FIFO is never written while full.
  - Overflow is a design error; an assertion must fire under simulation.
- Stream interface:
  - o_valid = FIFO not empty; o_data and o_last come from the FIFO head.
  - Pop on o_valid && i_ready.
  - Simultaneous push and pop in the same cycle leaves the count unchanged.
  - o_data, o_valid and o_last must hold stable while o_valid && !i_ready.
- Throughput: with i_ready held high, sustain 1 beat/clock after an initial latency. The first o_valid appears RD_LAT+1 clocks after entering ISSUE.
- Boundary cases:
  - NUM_WORDS=1: single beat, with o_last=1 on it.
  - The counter never wraps within a frame; the address after the last issue is don't-care but held.
  - i_ram_ready dropping during ISSUE does not pause the frame.

Optional Feature:
- Macro: EMBED_RD_CHKSUM_EN.
- When defined:
  - Adds output o_checksum [23:0].
  - Accumulates the sum of all 32 two-bit fields of every accepted beat.
  - Cleared on i_start in IDLE and on reset.
  - Final value is valid in the cycle o_done pulses, and held until the next start.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Full frame, unthrottled:
  - Stimulus: RAM model word[a]=a, NUM_WORDS=16, i_ready=1, pulse i_start with i_ram_ready=1.
  - Response: 16 consecutive beats 0..15; o_last only on beat 15; o_done 1 clock after the last accept; first o_valid 3 clocks after ISSUE entry.
- Back-pressure:
  - Stimulus: i_ready toggled in a 0,0,1 pattern.
  - Response: all 16 words arrive in order with no loss or duplication; never more than 4 entries in the FIFO plus in flight; data stable while stalled.
- Wait for RAM:
  - Stimulus: i_start with i_ram_ready=0 for 10 clocks.
  - Response: no o_rd_addr change and o_valid=0 until ready rises; then a normal frame.
- Single-word frame:
  - Stimulus: NUM_WORDS=1.
  - Response: one beat with o_last=1, then o_done.
- Reset mid-frame:
  - Stimulus: assert s_rst after beat 5; restart with i_start.
  - Response: outputs return to reset values immediately; the next frame starts at address 0 and is complete.
- Checksum, EMBED_RD_CHKSUM_EN only:
  - Stimulus: all words = 64'h5555_5555_5555_5555 (each field=1), NUM_WORDS=16.
  - Response: o_checksum = 512 at o_done.

Source files
------------

// File: rtl/embed_stream_reader.sv
// Streams a frame out of the patch-embedding RAM onto a valid/ready link.
// Optional running field checksum on o_checksum when EMBED_RD_CHKSUM_EN is defined.
module embed_stream_reader #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 12,
  parameter int NUM_WORDS  = 4096,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_start,
  input  logic              i_ram_ready,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
`ifdef EMBED_RD_CHKSUM_EN
  ,
  output logic [23:0]       o_checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] vld_q, lst_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mlast_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, infl;
  logic              issue, is_last, push, pop, credit;

  always_comb begin
    infl = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      infl = infl + CW'(vld_q[k]);
    end
  end

  // Reserve a FIFO slot for every read still in the RAM pipeline.
  assign credit  = ({1'b0, cnt_q} + {1'b0, infl}) < (CW + 1)'(FIFO_DEPTH);
  assign issue   = (state_q == S_ISSUE) && credit;
  assign is_last = (addr_q == LAST_ADDR);
  assign push    = vld_q[RD_LAT-1];
  assign pop     = o_valid && i_ready;

  assign o_valid   = (cnt_q != '0);
  assign o_data    = mem_q[rptr_q];
  assign o_last    = mlast_q[rptr_q];
  assign o_rd_addr = addr_q;
  assign o_busy    = (state_q == S_WAIT) || (state_q == S_ISSUE) ||
                     (state_q == S_DRAIN);
  assign o_done    = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_WAIT;
      S_WAIT: begin
        if (i_ram_ready) begin
          state_d = S_ISSUE;
          addr_d  = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (is_last) state_d = S_DRAIN;
          else addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: if (pop && o_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      vld_q[0] <= issue;
      lst_q[0] <= issue && is_last;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      mlast_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q]   <= i_rd_data;
        mlast_q[wptr_q] <= lst_q[RD_LAT-1];
        wptr_q          <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge s_clk) disable iff (s_rst)
    !(push && (cnt_q == CW'(FIFO_DEPTH))));

`ifdef EMBED_RD_CHKSUM_EN
  logic [23:0] chk_q;
  logic [7:0]  fsum;

  always_comb begin
    fsum = '0;
    for (int i = 0; i < DATA_W / 2; i++) begin
      fsum = fsum + 8'(o_data[2*i +: 2]);
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      chk_q <= '0;
    end else if ((state_q == S_IDLE) && i_start) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q + 24'(fsum);
    end
  end

  assign o_checksum = chk_q;
`endif

endmodule

// File: tb/tb_embed_stream_reader.sv
// Directed/randomised bench for embed_stream_reader (16-word and 1-word frames).
// Builds with or without EMBED_RD_CHKSUM_EN.
module tb_embed_stream_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st16, st1, rdy_ram, rdy;
  logic [11:0] a16, a1;
  logic [63:0] d16, d1, q16, q1;
  logic        v16, v1, l16, l1, b16, b1, dn16, dn1;
  logic [63:0] ram [16];
  logic [63:0] p16a, p16b, p1a, p1b;
`ifdef EMBED_RD_CHKSUM_EN
  logic [23:0] cs16, cs1;
`endif

  int ncmp = 0;
  int nfail = 0;
  logic [23:0] done_cs;

  embed_stream_reader #(.NUM_WORDS(16)) dut (
    .s_clk(clk), .s_rst(rst), .i_start(st16), .i_ram_ready(rdy_ram),
    .o_rd_addr(a16), .i_rd_data(d16), .o_data(q16), .o_valid(v16),
    .i_ready(rdy), .o_last(l16), .o_busy(b16), .o_done(dn16)
`ifdef EMBED_RD_CHKSUM_EN
    , .o_checksum(cs16)
`endif
  );

  embed_stream_reader #(.NUM_WORDS(1)) dut1 (
    .s_clk(clk), .s_rst(rst), .i_start(st1), .i_ram_ready(rdy_ram),
    .o_rd_addr(a1), .i_rd_data(d1), .o_data(q1), .o_valid(v1),
    .i_ready(rdy), .o_last(l1), .o_busy(b1), .o_done(dn1)
`ifdef EMBED_RD_CHKSUM_EN
    , .o_checksum(cs1)
`endif
  );

  // Two-clock RAM read pipeline per instance.
  always @(posedge clk) begin
    p16a <= ram[a16[3:0]];
    p16b <= p16a;
    p1a  <= ram[a1[3:0]];
    p1b  <= p1a;
  end
  assign d16 = p16b;
  assign d1  = p1b;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fields(input logic [63:0] w);
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'((w >> (2 * i)) & 64'd3);
    return s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, 64'(a16), 0);
    chk({tag, "_valid"}, 64'(v16), 0);
    chk({tag, "_last"}, 64'(l16), 0);
    chk({tag, "_busy"}, 64'(b16), 0);
    chk({tag, "_done"}, 64'(dn16), 0);
    chk({tag, "_data"}, q16, 0);
  endtask

  // Runs one frame; cycle 0 is the cycle in which the caller's inputs apply.
  task automatic collect(input bit sel, input int mode, input int lat,
                         input int stop_at);
    int n, got, first, last_c, csum;
    bit seen_done, stop, pv, pr, pl, mv, ml, mb, md;
    logic [63:0] pd, mq;
    n = sel ? 1 : 16;
    got = 0; first = -1; last_c = -100; csum = 0;
    seen_done = 0; stop = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    for (int c = 0; c < 400 && !seen_done && !stop; c++) begin
      unique case (mode)
        0: rdy = 1'b1;
        1: rdy = (c % 3 == 2);
        default: begin
          rdy = 1'($urandom_range(0, 1));
          if (c >= 2) rdy_ram = 1'($urandom_range(0, 1));
        end
      endcase
      @(negedge clk);
      mv = sel ? v1 : v16;
      ml = sel ? l1 : l16;
      mb = sel ? b1 : b16;
      md = sel ? dn1 : dn16;
      mq = sel ? q1 : q16;
      if (pv && !pr) begin
        chk("stall_valid", 64'(mv), 1);
        chk("stall_data", mq, pd);
        chk("stall_last", 64'(ml), 64'(pl));
      end
      if (mv && first < 0) begin
        first = c;
        if (lat >= 0) chk("first_valid_lat", 64'(c), 64'(lat));
      end
      if (md) begin
        seen_done = 1;
        chk("done_gap", 64'(c - last_c), 1);
        chk("busy_at_done", 64'(mb), 0);
`ifdef EMBED_RD_CHKSUM_EN
        done_cs = sel ? cs1 : cs16;
        chk("checksum", 64'(done_cs), 64'(csum));
`endif
      end
      if (mv && rdy) begin
        chk("beat_data", mq, (got < n) ? ram[got] : 64'hx);
        chk("beat_last", 64'(ml), 64'(got == n - 1));
        csum += fields(mq);
        got++;
        last_c = c;
        if (got == stop_at) stop = 1;
      end
      pv = mv; pr = rdy; pl = ml; pd = mq;
      @(posedge clk);
      #1;
      st16 = 1'b0;
      st1 = 1'b0;
    end
    rdy_ram = 1'b1;
    if (stop_at < 0) begin
      chk("beat_count", 64'(got), 64'(n));
      chk("done_seen", 64'(seen_done), 1);
      @(negedge clk);
      chk("done_one_cycle", 64'(sel ? dn1 : dn16), 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [11:0] hold_a;
    rst = 1'b1; st16 = 0; st1 = 0; rdy_ram = 0; rdy = 0;
    done_cs = '0;
    for (int i = 0; i < 16; i++) ram[i] = 64'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_rel");
    @(posedge clk);
    #1;

    // Full frame, word[a]=a, unthrottled.
    rdy_ram = 1'b1; st16 = 1'b1;
    collect(0, 0, 5, -1);

    // Random contents with 0,0,1 back-pressure.
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom};
    st16 = 1'b1;
    collect(0, 1, 5, -1);

    // Start while RAM not ready: nothing moves for 10 clocks.
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom};
    hold_a = a16;
    rdy_ram = 1'b0; st16 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("wait_addr", 64'(a16), 64'(hold_a));
      chk("wait_valid", 64'(v16), 0);
      if (c > 0) chk("wait_busy", 64'(b16), 1);
      @(posedge clk);
      #1;
      st16 = 1'b0;
    end
    rdy_ram = 1'b1;
    collect(0, 2, 4, -1);

    // Single-word frames.
    st1 = 1'b1;
    collect(1, 0, 5, -1);
    st1 = 1'b1;
    collect(1, 1, 5, -1);

    // Reset after beat 5, then a complete restart.
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom};
    st16 = 1'b1;
    collect(0, 2, 5, 5);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    @(negedge clk);
    chk_reset("mid_rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    st16 = 1'b1;
    collect(0, 0, 5, -1);

    // Random back-pressure on a fresh random frame.
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom};
    st16 = 1'b1;
    collect(0, 2, 5, -1);

`ifdef EMBED_RD_CHKSUM_EN
    for (int i = 0; i < 16; i++) ram[i] = 64'h5555_5555_5555_5555;
    st16 = 1'b1;
    collect(0, 2, 5, -1);
    chk("cs_512", 64'(done_cs), 64'd512);
    repeat (3) @(posedge clk);
    #1;
    chk("cs_hold", 64'(cs16), 64'd512);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
